// File: rtl/bit_set_serializer_pkg.sv
// bit_set_serializer_pkg: shared widths and state encoding for the bit-set serializer
package bit_set_serializer_pkg;
  localparam int WIDTH = 8;
  localparam int IDXW = 3;
  localparam int OHW = WIDTH;
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;
endpackage

// File: rtl/bit_set_serializer_lsb_finder.sv
// bit_set_serializer_lsb_finder: priority encoder for the lowest set bit of a word
// ports: word_i word in; idx_o lowest set index; onehot_o that bit alone; more_o word still nonzero once that bit is cleared
module bit_set_serializer_lsb_finder
  import bit_set_serializer_pkg::*;
(
  input  logic [WIDTH-1:0] word_i,
  output logic [IDXW-1:0]  idx_o,
  output logic [OHW-1:0]   onehot_o,
  output logic             more_o
);
  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (word_i[i]) idx_o = IDXW'(i);
  end
  assign onehot_o = word_i & (~word_i + 1'b1);
  assign more_o = |(word_i & (word_i - 1'b1));
endmodule

// File: rtl/bit_set_serializer.sv
// bit_set_serializer: accepts a flag word and emits its set bits lowest-first, one per transfer
// ports: clk_i/rst_ni clock and async active-low reset; in_valid_i/in_ready_o/in_data_i word handshake;
//        out_valid_o/out_ready_i element handshake; out_index_o/out_onehot_o/out_last_o element; busy_o serializing
module bit_set_serializer
  import bit_set_serializer_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IDXW-1:0]  out_index_o,
  output logic [OHW-1:0]   out_onehot_o,
  output logic             out_last_o,
  output logic             busy_o
);
  state_e           state_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             valid_q, last_q;
  logic [IDXW-1:0]  idx_q;
  logic [OHW-1:0]   oh_q;
  logic [IDXW-1:0]  ld_idx, adv_idx;
  logic [OHW-1:0]   ld_oh, adv_oh;
  logic             ld_more, adv_more;
  // residual with the element currently on the outputs removed
  assign res_d = res_q & (res_q - 1'b1);
  bit_set_serializer_lsb_finder u_ld (.word_i(in_data_i), .idx_o(ld_idx), .onehot_o(ld_oh), .more_o(ld_more));
  bit_set_serializer_lsb_finder u_adv (.word_i(res_d), .idx_o(adv_idx), .onehot_o(adv_oh), .more_o(adv_more));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      res_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      oh_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i && |in_data_i) begin
          state_q <= EMIT;
          res_q   <= in_data_i;
          valid_q <= 1'b1;
          idx_q   <= ld_idx;
          oh_q    <= ld_oh;
          last_q  <= !ld_more;
        end
        EMIT: if (out_ready_i) begin
          if (last_q) begin
            state_q <= IDLE;
            res_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            oh_q    <= '0;
            last_q  <= 1'b0;
          end else begin
            res_q  <= res_d;
            idx_q  <= adv_idx;
            oh_q   <= adv_oh;
            last_q <= !adv_more;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready_o   = (state_q == IDLE);
  assign out_valid_o  = valid_q;
  assign out_index_o  = idx_q;
  assign out_onehot_o = oh_q;
  assign out_last_o   = last_q;
  assign busy_o       = valid_q;
endmodule

// File: tb/tb_bit_set_serializer.sv
// tb_bit_set_serializer: directed self-checking bench for bit_set_serializer
module tb_bit_set_serializer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_last, busy;
  logic [2:0] out_index;
  logic [7:0] out_onehot;
  int checks = 0;
  int failures = 0;
  // observed bundle: {valid, index, onehot, last, in_ready, busy}
  wire [14:0] obs = {out_valid, out_index, out_onehot, out_last, in_ready, busy};

  always #5 clk = ~clk;

  bit_set_serializer dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_index_o(out_index), .out_onehot_o(out_onehot), .out_last_o(out_last), .busy_o(busy)
  );

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (obs !== {1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset got %h exp %h", obs, {1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_a5();
    logic [2:0] ei [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
    logic [7:0] eo [4] = '{8'h01, 8'h04, 8'h20, 8'h80};
    logic [14:0] e;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = {1'b1, ei[k], eo[k], k == 3, 1'b0, 1'b1};
      checks++;
      if (obs !== e) begin failures++; $display("FAIL a5_elem%0d got %h exp %h", k, obs, e); end
      @(negedge clk);
    end
    checks++;
    if (obs !== 15'b0_000_00000000_0_1_0) begin failures++; $display("FAIL a5_done got %h exp %h", obs, 15'b0_000_00000000_0_1_0); end
  endtask

  task automatic test_zero_then_80();
    in_valid = 1'b1; in_data = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs !== 15'b0_000_00000000_0_1_0) begin failures++; $display("FAIL zero_idle%0d got %h exp %h", k, obs, 15'b0_000_00000000_0_1_0); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h80;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 3'd7, 8'h80, 1'b1, 1'b0, 1'b1}) begin failures++; $display("FAIL x80_elem got %h exp %h", obs, {1'b1, 3'd7, 8'h80, 1'b1, 1'b0, 1'b1}); end
    @(negedge clk);
    checks++;
    if (obs !== 15'b0_000_00000000_0_1_0) begin failures++; $display("FAIL x80_done got %h exp %h", obs, 15'b0_000_00000000_0_1_0); end
  endtask

  task automatic test_back_to_back_ff();
    logic [14:0] e;
    logic [7:0] oh;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    oh = 8'h01;
    for (int k = 0; k < 8; k++) begin
      e = {1'b1, 3'(k), oh, k == 7, 1'b0, 1'b1};
      checks++;
      if (obs !== e) begin failures++; $display("FAIL ff_elem%0d got %h exp %h", k, obs, e); end
      oh = oh << 1;
      @(negedge clk);
    end
    checks++;
    if (obs !== 15'b0_000_00000000_0_1_0) begin failures++; $display("FAIL ff_done got %h exp %h", obs, 15'b0_000_00000000_0_1_0); end
    in_valid = 1'b1; in_data = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b1}) begin failures++; $display("FAIL ff_next got %h exp %h", obs, {1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b1}); end
    @(negedge clk);
  endtask

  task automatic test_backpressure_12();
    logic       rdy [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [14:0] ex [6] = '{
      {1'b1, 3'd1, 8'h02, 1'b0, 1'b0, 1'b1},
      {1'b1, 3'd1, 8'h02, 1'b0, 1'b0, 1'b1},
      {1'b1, 3'd1, 8'h02, 1'b0, 1'b0, 1'b1},
      {1'b1, 3'd4, 8'h10, 1'b1, 1'b0, 1'b1},
      {1'b1, 3'd4, 8'h10, 1'b1, 1'b0, 1'b1},
      {1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0}};
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h12;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (obs !== ex[k]) begin failures++; $display("FAIL bp_step%0d got %h exp %h", k, obs, ex[k]); end
      if (k < 5) out_ready = rdy[k];
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h0F;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 3'd1, 8'h02, 1'b0, 1'b0, 1'b1}) begin failures++; $display("FAIL rst_second got %h exp %h", obs, {1'b1, 3'd1, 8'h02, 1'b0, 1'b0, 1'b1}); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 15'b0_000_00000000_0_1_0) begin failures++; $display("FAIL rst_async got %h exp %h", obs, 15'b0_000_00000000_0_1_0); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 15'b0_000_00000000_0_1_0) begin failures++; $display("FAIL rst_after got %h exp %h", obs, 15'b0_000_00000000_0_1_0); end
    in_valid = 1'b1; in_data = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b1}) begin failures++; $display("FAIL rst_new got %h exp %h", obs, {1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b1}); end
    @(negedge clk);
    checks++;
    if (obs !== 15'b0_000_00000000_0_1_0) begin failures++; $display("FAIL rst_new_done got %h exp %h", obs, 15'b0_000_00000000_0_1_0); end
  endtask

  task automatic test_ignore_during_emit();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h03;
    @(negedge clk);
    in_data = 8'h40;
    checks++;
    if (obs !== {1'b1, 3'd0, 8'h01, 1'b0, 1'b0, 1'b1}) begin failures++; $display("FAIL ign_e0 got %h exp %h", obs, {1'b1, 3'd0, 8'h01, 1'b0, 1'b0, 1'b1}); end
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 3'd1, 8'h02, 1'b1, 1'b0, 1'b1}) begin failures++; $display("FAIL ign_e1 got %h exp %h", obs, {1'b1, 3'd1, 8'h02, 1'b1, 1'b0, 1'b1}); end
    @(negedge clk);
    checks++;
    if (obs !== 15'b0_000_00000000_0_1_0) begin failures++; $display("FAIL ign_idle got %h exp %h", obs, 15'b0_000_00000000_0_1_0); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 3'd6, 8'h40, 1'b1, 1'b0, 1'b1}) begin failures++; $display("FAIL ign_new got %h exp %h", obs, {1'b1, 3'd6, 8'h40, 1'b1, 1'b0, 1'b1}); end
    @(negedge clk);
    checks++;
    if (obs !== 15'b0_000_00000000_0_1_0) begin failures++; $display("FAIL ign_done got %h exp %h", obs, 15'b0_000_00000000_0_1_0); end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_zero_then_80();
    test_back_to_back_ff();
    test_backpressure_12();
    test_async_reset();
    test_ignore_during_emit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
